shift_issue: RTL and testbench
==============================

# shift_issue

Decode-and-issue stage for R-type shift instructions, directly upstream of the combinational shifter in EX. Accepts an instruction word with its register operands over a valid/ready handshake and decodes the funct field into the shifter's way, data and amount controls. Decoded entries are buffered in a 2-entry FIFO, so a stalled EX does not immediately back-pressure ID. Illegal encodings are rejected with an error pulse, and a flush input empties the buffer.

## Interface
- DEPTH, 2, FIFO entries; fixed at 2, other values unsupported
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous clear of the FIFO and pending error
- in_valid  in  1  instruction and operands valid
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- rs_val  in  32  rs register value
- rt_val  in  32  rt register value
- out_valid  out  1  head entry valid
- out_ready  in  1  EX consumes head entry this cycle
- way  out  2  00 logical left, 01 logical right, 10 arithmetic left, 11 arithmetic right
- data_in  out  32  operand to shift (rt_val)
- shift_num  out  5  shift amount
- rd  out  5  destination register
- illegal  out  1  one-cycle pulse for a rejected instruction
- illegal_instr  out  32  last rejected instruction word

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- `in_ready = !full && !flush`. No write-through when full, even if a pop occurs in the same cycle.
- Decode requires opcode `instr[31:26]==0`. Otherwise the instruction is illegal.
- funct 000000 SLL → way 00, amount `instr[10:6]`.
- funct 000010 SRL → way 01, amount `instr[10:6]`.
- funct 000011 SRA → way 11, amount `instr[10:6]`.
- funct 000100 SLLV → way 00, amount `rs_val[4:0]`.
- funct 000110 SRLV → way 01, amount `rs_val[4:0]`.
- funct 000111 SRAV → way 11, amount `rs_val[4:0]`.
- Way 10 is never generated. Any other funct is illegal.
- `data_in = rt_val`. `rd = instr[15:11]`.
- Legal instruction with rd==0 (covers NOP 0x00000000): accepted and discarded. Not enqueued, no error.
- Illegal instruction: accepted and not enqueued. `illegal` pulses high the next cycle, and `illegal_instr` is updated with the instruction word.
- FIFO: write pointer, read pointer, and a 0..2 count.
  - Push and pop in the same cycle: count unchanged, pointers both advance, wrapping modulo 2.
  - Pop when empty: impossible, since `out_valid=0`.
- flush: count, pointers and `illegal` go to 0 at the next edge. The input is not accepted that cycle. A concurrent pop is ignored. `illegal_instr` is retained.
- Reset values: `out_valid=0`, `illegal=0`, `illegal_instr=0`, pointers and count 0. `way`, `data_in`, `shift_num` and `rd` show entry 0, which is reset to zero.

## Timing
- Accept at edge N → `out_valid` and the decoded fields are visible after edge N (1-cycle latency).
- Output fields are stable while `out_valid && !out_ready`.
- Full throughput: 1 instruction per cycle when EX never stalls.
- Reset asserted mid-operation: all state clears immediately (asynchronous). The first accept is possible on the first edge after release.

## Configuration
- SHIFT_ISSUE_VAR_EN defined: SLLV, SRLV and SRAV are decoded as above.
- Not defined: funct 000100, 000110 and 000111 are treated as illegal. `rs_val` is unused.

## Structure
- Package `shift_pkg` holds:
  - way encodings: WAY_SLL, WAY_SRL, WAY_SLA, WAY_SRA
  - funct constants: FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV
  - packed entry typedef `shift_entry_t` {way, data, num, rd}
- Sub-module `shift_fifo2`: a 2-entry FIFO of `shift_entry_t` with push, pop, flush, full and empty. Decode logic stays in `shift_issue`.

## Test plan
- `sra $3,$2,4`: instr 0x00021903, rt_val 0x80000000 → next cycle `out_valid=1`, way 11, data_in 0x80000000, shift_num 4, rd 3.
- `sllv $5,$6,$7`: instr 0x00E62804, rs_val 0x00000024 → way 00, shift_num 4, rd 5. With the macro undefined → `illegal` pulse, `illegal_instr=0x00E62804`, `out_valid` stays 0.
- Hold `out_ready=0` and send 3 legal instructions → first two accepted, `in_ready=0` on the third. Raise `out_ready` → entries drain in order, then the third is accepted.
- Instr 0x00000000 → accepted, `out_valid` stays 0, no `illegal`. Instr 0x8C000000 (lw) → `illegal` pulse.
- FIFO holding 2 entries, then `flush` with `in_valid=1` → next cycle `out_valid=0`, the input was not accepted, count 0.
- Drop `rst_n` while `out_valid=1` between edges → `out_valid` and `illegal` go 0 at once, no clock edge needed.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings and the buffered entry layout for the shift issue stage.
// Way encodings match the EX shifter's control field.
package shift_pkg;

  localparam logic [1:0] WAY_SLL = 2'b00;
  localparam logic [1:0] WAY_SRL = 2'b01;
  localparam logic [1:0] WAY_SLA = 2'b10;
  localparam logic [1:0] WAY_SRA = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;

  typedef struct packed {
    logic [1:0]  way;
    logic [31:0] data;
    logic [4:0]  num;
    logic [4:0]  rd;
  } shift_entry_t;

endpackage

// File: rtl/shift_fifo2.sv
// Two-entry FIFO of decoded shift entries with synchronous flush.
// Latency: a push is visible at the head after the next edge.
// Backpressure: full blocks pushes, even when a pop happens in the same cycle.
module shift_fifo2
  import shift_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  shift_entry_t wr_dat,
  output shift_entry_t rd_dat,
  output logic         full,
  output logic         empty
);

  shift_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Flush only resets bookkeeping; stale payload stays behind a cleared count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/shift_issue.sv
// Decode-and-issue for R-type shifts into a 2-deep buffer ahead of EX; SHIFT_ISSUE_VAR_EN adds SLLV/SRLV/SRAV.
// Latency: accepted instruction appears on out_valid one cycle later; illegal pulses one cycle later.
// Backpressure: in_ready drops when the buffer is full or flush is high.
module shift_issue
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  way,
  output logic [31:0] data_in,
  output logic [4:0]  shift_num,
  output logic [4:0]  rd,
  output logic        illegal,
  output logic [31:0] illegal_instr
);

  logic         full;
  logic         empty;
  logic         accept;
  logic         legal;
  logic [1:0]   dec_way;
  logic [4:0]   dec_num;
  logic         push;
  shift_entry_t wr_dat;
  shift_entry_t head;

  assign in_ready = !full && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    legal   = 1'b0;
    dec_way = WAY_SLL;
    dec_num = instr[10:6];
    if (instr[31:26] == OP_RTYPE) begin
      case (instr[5:0])
        FN_SLL:  begin legal = 1'b1; dec_way = WAY_SLL; end
        FN_SRL:  begin legal = 1'b1; dec_way = WAY_SRL; end
        FN_SRA:  begin legal = 1'b1; dec_way = WAY_SRA; end
`ifdef SHIFT_ISSUE_VAR_EN
        FN_SLLV: begin legal = 1'b1; dec_way = WAY_SLL; dec_num = rs_val[4:0]; end
        FN_SRLV: begin legal = 1'b1; dec_way = WAY_SRL; dec_num = rs_val[4:0]; end
        FN_SRAV: begin legal = 1'b1; dec_way = WAY_SRA; dec_num = rs_val[4:0]; end
`endif
        default: ;
      endcase
    end
  end

`ifdef SHIFT_ISSUE_VAR_EN
  logic unused_bits;
  assign unused_bits = ^{instr[25:16], rs_val[31:5]};
`else
  logic unused_bits;
  assign unused_bits = ^{instr[25:16], rs_val};
`endif

  // Writes to $0 are architecturally dead, so they never occupy a slot.
  assign push   = accept && legal && (instr[15:11] != 5'd0);
  assign wr_dat = '{way: dec_way, data: rt_val, num: dec_num, rd: instr[15:11]};

  shift_fifo2 u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .push   (push),
    .pop    (out_ready),
    .wr_dat (wr_dat),
    .rd_dat (head),
    .full   (full),
    .empty  (empty)
  );

  assign out_valid = !empty;
  assign way       = head.way;
  assign data_in   = head.data;
  assign shift_num = head.num;
  assign rd        = head.rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal       <= 1'b0;
      illegal_instr <= 32'd0;
    end else if (flush) begin
      illegal <= 1'b0;
    end else begin
      illegal <= accept && !legal;
      if (accept && !legal) illegal_instr <= instr;
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
// Randomized and directed checks of shift_issue against a queue-based reference model.
module tb_shift_issue;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  way;
  logic [31:0] data_in;
  logic [4:0]  shift_num;
  logic [4:0]  rd;
  logic        illegal;
  logic [31:0] illegal_instr;

  int tests = 0;
  int fails = 0;

  shift_entry_t q[$];
  logic         m_illegal;
  logic [31:0]  m_illegal_instr;

  always #5 clk = ~clk;

  shift_issue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr         (instr),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .way           (way),
    .data_in       (data_in),
    .shift_num     (shift_num),
    .rd            (rd),
    .illegal       (illegal),
    .illegal_instr (illegal_instr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: which shifts exist, and where their amount comes from.
  function automatic bit ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                    input logic [31:0] rt, output shift_entry_t e);
    int  fn;
    bit  ok;
    ok = 0;
    e  = '0;
    fn = int'(ins[5:0]);
    e.data = rt;
    e.rd   = ins[15:11];
    e.num  = ins[10:6];
    if (ins[31:26] == 6'd0) begin
      if (fn == 0)      begin ok = 1; e.way = 2'd0; end
      else if (fn == 2) begin ok = 1; e.way = 2'd1; end
      else if (fn == 3) begin ok = 1; e.way = 2'd3; end
`ifdef SHIFT_ISSUE_VAR_EN
      else if (fn == 4) begin ok = 1; e.way = 2'd0; e.num = rs[4:0]; end
      else if (fn == 6) begin ok = 1; e.way = 2'd1; e.num = rs[4:0]; end
      else if (fn == 7) begin ok = 1; e.way = 2'd3; e.num = rs[4:0]; end
`endif
    end
    return ok;
  endfunction

  task automatic model_reset();
    q.delete();
    m_illegal       = 1'b0;
    m_illegal_instr = 32'd0;
  endtask

  task automatic check_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("illegal", {31'd0, illegal}, {31'd0, m_illegal});
    chk("illegal_instr", illegal_instr, m_illegal_instr);
    if (q.size() > 0) begin
      chk("way", {30'd0, way}, {30'd0, q[0].way});
      chk("data_in", data_in, q[0].data);
      chk("shift_num", {27'd0, shift_num}, {27'd0, q[0].num});
      chk("rd", {27'd0, rd}, {27'd0, q[0].rd});
    end
  endtask

  // Drive one cycle of inputs, advance one edge, then compare against the model.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] rs,
                      input logic [31:0] rt, input logic ordy, input logic fl);
    bit           exp_rdy;
    bit           ok;
    shift_entry_t e;
    in_valid  = iv;
    instr     = ins;
    rs_val    = rs;
    rt_val    = rt;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = (q.size() < 2) && !fl;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_illegal = 1'b0;
    end else begin
      if (ordy && q.size() > 0) void'(q.pop_front());
      m_illegal = 1'b0;
      if (iv && exp_rdy) begin
        ok = ref_decode(ins, rs, rt, e);
        if (!ok) begin
          m_illegal       = 1'b1;
          m_illegal_instr = ins;
        end else if (e.rd != 5'd0) begin
          q.push_back(e);
        end
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, 32'd0, 32'd0, ordy, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rdf;
    int         pick;
    op   = ($urandom_range(9) == 0) ? 6'($urandom) : 6'd0;
    pick = $urandom_range(7);
    case (pick)
      0: fn = 6'd0;
      1: fn = 6'd2;
      2: fn = 6'd3;
      3: fn = 6'd4;
      4: fn = 6'd6;
      5: fn = 6'd7;
      default: fn = 6'($urandom);
    endcase
    rdf = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
    return {op, 10'($urandom), rdf, 5'($urandom), fn};
  endfunction

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = 32'd0;
    rs_val    = 32'd0;
    rt_val    = 32'd0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_illegal_instr", illegal_instr, 32'd0);
    chk("rst_fields", {way, data_in[24:0], shift_num}, 32'd0);
    chk("rst_data_hi", {data_in[31:25], rd}, 32'd0);
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // sra $3,$2,4
    step(1'b1, 32'h00021903, 32'd0, 32'h80000000, 1'b0, 1'b0);
    chk("sra_out_valid", {31'd0, out_valid}, 32'd1);
    chk("sra_way", {30'd0, way}, 32'd3);
    chk("sra_data", data_in, 32'h80000000);
    chk("sra_num", {27'd0, shift_num}, 32'd4);
    chk("sra_rd", {27'd0, rd}, 32'd3);
    idle(1'b1);

    // sllv $5,$6,$7
    step(1'b1, 32'h00E62804, 32'h00000024, 32'h12345678, 1'b0, 1'b0);
`ifdef SHIFT_ISSUE_VAR_EN
    chk("sllv_way", {30'd0, way}, 32'd0);
    chk("sllv_num", {27'd0, shift_num}, 32'd4);
    chk("sllv_rd", {27'd0, rd}, 32'd5);
`else
    chk("sllv_illegal", {31'd0, illegal}, 32'd1);
    chk("sllv_illegal_instr", illegal_instr, 32'h00E62804);
    chk("sllv_out_valid", {31'd0, out_valid}, 32'd0);
`endif
    idle(1'b1);

    // Fill with out_ready low, third is held, then drain in order.
    step(1'b1, 32'h00000840, 32'd0, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'h00001082, 32'd0, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'h000018C3, 32'd0, 32'hC, 1'b0, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head_rd", {27'd0, rd}, 32'd1);
    step(1'b1, 32'h000018C3, 32'd0, 32'hC, 1'b1, 1'b0);
    chk("drain_head_rd2", {27'd0, rd}, 32'd2);
    step(1'b1, 32'h000018C3, 32'd0, 32'hC, 1'b1, 1'b0);
    chk("drain_head_rd3", {27'd0, rd}, 32'd3);
    chk("drain_data_c", data_in, 32'hC);
    idle(1'b1);

    // NOP is dropped silently, lw is rejected.
    step(1'b1, 32'h00000000, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("nop_out_valid", {31'd0, out_valid}, 32'd0);
    chk("nop_illegal", {31'd0, illegal}, 32'd0);
    step(1'b1, 32'h8C000000, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("lw_illegal", {31'd0, illegal}, 32'd1);
    chk("lw_illegal_instr", illegal_instr, 32'h8C000000);
    idle(1'b1);
    chk("lw_pulse_end", {31'd0, illegal}, 32'd0);

    // Flush a full buffer while offering an input.
    step(1'b1, 32'h00000840, 32'd0, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h00001080, 32'd0, 32'h2, 1'b0, 1'b0);
    step(1'b1, 32'h000018C0, 32'd0, 32'h3, 1'b1, 1'b1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    idle(1'b0);
    chk("flush_not_accepted", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges.
    step(1'b1, 32'h00002140, 32'd0, 32'h5, 1'b0, 1'b0);
    step(1'b1, 32'hFC000000, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_illegal", {31'd0, illegal}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_illegal", {31'd0, illegal}, 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    #1;
    step(1'b1, 32'h00003943, 32'd0, 32'h77, 1'b0, 1'b0);
    chk("post_rst_accept", {31'd0, out_valid}, 32'd1);
    chk("post_rst_rd", {27'd0, rd}, 32'd7);
    idle(1'b1);

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(4) != 0), rand_instr(), $urandom, $urandom,
           1'($urandom_range(9) < 7), 1'($urandom_range(19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
